// File: rtl/syscall_responder.sv
// Syscall service engine: prints signed ints, NUL-terminated strings and chars on a
// valid/ready byte stream. Define SYSCALL_EXIT_EN to build the sticky exit/halt service.
module syscall_responder #(
    parameter int STR_MAX = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sys_req,
    input  logic [31:0] sys_v,
    input  logic [31:0] sys_a,
    output logic        busy,
    output logic        halt,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready
);

    localparam int CW = $clog2(STR_MAX + 1);
    localparam logic [31:0] SVC_INT  = 32'd1;
    localparam logic [31:0] SVC_STR  = 32'd4;
    localparam logic [31:0] SVC_CHR  = 32'd11;
`ifdef SYSCALL_EXIT_EN
    localparam logic [31:0] SVC_EXIT = 32'd10;
`endif

    typedef enum logic [3:0] {
        IDLE,
        INT_CONV,
        INT_SIGN,
        INT_EMIT,
        STR_FETCH,
        STR_WAIT,
        STR_EMIT,
        CHR_EMIT
`ifdef SYSCALL_EXIT_EN
        , HALTED
`endif
    } stateType;

    stateType       stateReg;
    logic [31:0]    magReg;
    logic           signReg;
    logic [3:0]     digitCnt;
    logic [3:0]     digitStack [10];
    logic [CW-1:0]  byteCnt;
    logic [31:0]    magDiv;
    logic [3:0]     magMod;

    assign magDiv = magReg / 32'd10;
    assign magMod = 4'(magReg % 32'd10);

    // Digit stack: the conversion pushes least-significant digit first at index digitCnt.
    for (genvar gi = 0; gi < 10; gi++) begin : gen_digit
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                digitStack[gi] <= 4'd0;
            end else if (stateReg == INT_CONV && digitCnt == 4'(gi)) begin
                digitStack[gi] <= magMod;
            end
        end
    end

`ifndef SYSCALL_EXIT_EN
    assign halt = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg  <= IDLE;
            busy      <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= 32'd0;
            out_valid <= 1'b0;
            out_data  <= 8'd0;
            magReg    <= 32'd0;
            signReg   <= 1'b0;
            digitCnt  <= 4'd0;
            byteCnt   <= '0;
`ifdef SYSCALL_EXIT_EN
            halt      <= 1'b0;
`endif
        end else begin
            mem_rd <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (sys_req) begin
                        if (sys_v == SVC_INT) begin
                            signReg  <= sys_a[31];
                            magReg   <= sys_a[31] ? (~sys_a + 32'd1) : sys_a;
                            digitCnt <= 4'd0;
                            busy     <= 1'b1;
                            stateReg <= INT_CONV;
                        end else if (sys_v == SVC_STR) begin
                            mem_addr <= sys_a;
                            mem_rd   <= 1'b1;
                            byteCnt  <= '0;
                            busy     <= 1'b1;
                            stateReg <= STR_FETCH;
                        end else if (sys_v == SVC_CHR) begin
                            out_data  <= sys_a[7:0];
                            out_valid <= 1'b1;
                            busy      <= 1'b1;
                            stateReg  <= CHR_EMIT;
`ifdef SYSCALL_EXIT_EN
                        end else if (sys_v == SVC_EXIT) begin
                            halt     <= 1'b1;
                            busy     <= 1'b1;
                            stateReg <= HALTED;
`endif
                        end
                    end
                end
                INT_CONV: begin
                    magReg   <= magDiv;
                    digitCnt <= digitCnt + 4'd1;
                    // Last digit computed this cycle is the most significant one.
                    if (magDiv == 32'd0) begin
                        out_valid <= 1'b1;
                        if (signReg) begin
                            out_data <= 8'h2D;
                            stateReg <= INT_SIGN;
                        end else begin
                            out_data <= {4'h3, magMod};
                            stateReg <= INT_EMIT;
                        end
                    end
                end
                INT_SIGN: begin
                    if (out_ready) begin
                        out_data <= {4'h3, digitStack[digitCnt - 4'd1]};
                        stateReg <= INT_EMIT;
                    end
                end
                INT_EMIT: begin
                    if (out_ready) begin
                        digitCnt <= digitCnt - 4'd1;
                        if (digitCnt == 4'd1) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            stateReg  <= IDLE;
                        end else begin
                            out_data <= {4'h3, digitStack[digitCnt - 4'd2]};
                        end
                    end
                end
                STR_FETCH: stateReg <= STR_WAIT;
                STR_WAIT: begin
                    if (mem_data == 8'h00) begin
                        busy     <= 1'b0;
                        stateReg <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                        out_data  <= mem_data;
                        stateReg  <= STR_EMIT;
                    end
                end
                STR_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (byteCnt == CW'(STR_MAX - 1)) begin
                            busy     <= 1'b0;
                            stateReg <= IDLE;
                        end else begin
                            mem_addr <= mem_addr + 32'd1;
                            mem_rd   <= 1'b1;
                            byteCnt  <= byteCnt + 1'b1;
                            stateReg <= STR_FETCH;
                        end
                    end
                end
                CHR_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        stateReg  <= IDLE;
                    end
                end
`ifdef SYSCALL_EXIT_EN
                HALTED: stateReg <= HALTED;
`endif
                default: stateReg <= IDLE;
            endcase
        end
    end

endmodule
